// File: rtl/i2si_ctrl.sv
// I2S input capture controller: arms on a word-select falling edge (or starts BIST directly),
// gates FIFO pushes, drains with timeout. Optional sample counter under I2SI_SAMPLE_CNT_EN.
module i2si_ctrl #(
  parameter int unsigned DRAIN_TMO_W = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rf_i2si_en,
  input  logic        rf_bist_en,
  input  logic        trig_i2si_fifo_overrun_clr,
  input  logic        i2si_ws,
  input  logic        src_xfc,
  input  logic        fifo_inp_rtr,
  input  logic        fifo_out_rts,
  output logic        deser_en,
  output logic        bist_run,
  output logic        mux_sel,
  output logic        fifo_push,
  output logic        ro_fifo_overrun,
  output logic        ro_drain_tmo,
  output logic [1:0]  ro_i2si_state,
  output logic [15:0] ro_i2si_sample_cnt
);

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StArm   = 2'd1,
    StRun   = 2'd2,
    StDrain = 2'd3
  } state_e;

  // Timeout fires on the edge where the counter becomes all-ones.
  localparam logic [DRAIN_TMO_W-1:0] TmoLast = {{(DRAIN_TMO_W-1){1'b1}}, 1'b0};

  state_e                 state_q, state_d;
  logic                   mode_q, mode_d;
  logic                   ws_q;
  logic [DRAIN_TMO_W-1:0] tmo_q, tmo_d;
  logic                   ovr_q, dtmo_q;
  logic                   ovr_set, dtmo_set;

  always_comb begin
    state_d  = state_q;
    mode_d   = mode_q;
    tmo_d    = tmo_q;
    deser_en = 1'b0;
    bist_run = 1'b0;
    ovr_set  = 1'b0;
    dtmo_set = 1'b0;
    case (state_q)
      StIdle: begin
        if (rf_i2si_en) begin
          mode_d  = rf_bist_en;
          state_d = rf_bist_en ? StRun : StArm;
        end
      end
      StArm: begin
        if (!rf_i2si_en) begin
          state_d = StIdle;
        end else if (ws_q && !i2si_ws) begin
          state_d = StRun;
        end
      end
      StRun: begin
        deser_en = ~mode_q;
        bist_run = mode_q;
        ovr_set  = src_xfc & ~fifo_inp_rtr;
        if (!rf_i2si_en || (rf_bist_en != mode_q)) begin
          state_d = StDrain;
          tmo_d   = '0;
        end
      end
      StDrain: begin
        tmo_d = tmo_q + 1'b1;
        if (!fifo_out_rts) begin
          state_d = StIdle;
        end else if (tmo_q == TmoLast) begin
          state_d  = StIdle;
          dtmo_set = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
      mode_q  <= 1'b0;
      ws_q    <= 1'b1;
      tmo_q   <= '0;
      ovr_q   <= 1'b0;
      dtmo_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      ws_q    <= i2si_ws;
      tmo_q   <= tmo_d;
      // Set wins over a simultaneous clear.
      if (ovr_set) begin
        ovr_q <= 1'b1;
      end else if (trig_i2si_fifo_overrun_clr) begin
        ovr_q <= 1'b0;
      end
      if (dtmo_set) begin
        dtmo_q <= 1'b1;
      end else if (trig_i2si_fifo_overrun_clr) begin
        dtmo_q <= 1'b0;
      end
    end
  end

  assign fifo_push       = (state_q == StRun) & src_xfc & fifo_inp_rtr;
  assign mux_sel         = mode_q;
  assign ro_fifo_overrun = ovr_q;
  assign ro_drain_tmo    = dtmo_q;
  assign ro_i2si_state   = state_q;

`ifdef I2SI_SAMPLE_CNT_EN
  logic        idle_exit;
  logic [15:0] cnt_q;

  assign idle_exit = (state_q == StIdle) & rf_i2si_en;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else if (idle_exit) begin
      cnt_q <= '0;
    end else if (fifo_push) begin
      cnt_q <= cnt_q + 16'd1;
    end
  end

  assign ro_i2si_sample_cnt = cnt_q;
`else
  assign ro_i2si_sample_cnt = '0;
`endif

endmodule

// File: doc/i2si_ctrl.md
I2SI_CTRL -- requirements
Module: i2si_ctrl

Interface
REQ-001 The block SHALL have parameter DRAIN_TMO_W, default 8, which sets the width of the drain timeout counter.
REQ-002 The block SHALL have port clk, input, 1, the single master clock; all state is updated on its rising edge.
REQ-003 The block SHALL have port rst, input, 1, reset, asynchronous and active-low.
REQ-004 The block SHALL have port rf_i2si_en, input, 1, the register-file capture enable.
REQ-005 The block SHALL have port rf_bist_en, input, 1, the register-file source select (0 = deserializer, 1 = BIST).
REQ-006 The block SHALL have port trig_i2si_fifo_overrun_clr, input, 1, a one-cycle pulse that clears the sticky status flags.
REQ-007 The block SHALL have port i2si_ws, input, 1, word select, already synchronized to clk.
REQ-008 The block SHALL have port src_xfc, input, 1, the sample-valid pulse from the mux output.
REQ-009 The block SHALL have port fifo_inp_rtr, input, 1, asserted when the FIFO can accept a word.
REQ-010 The block SHALL have port fifo_out_rts, input, 1, asserted when the FIFO is non-empty.
REQ-011 The block SHALL have port deser_en, output, 1, the deserializer run enable.
REQ-012 The block SHALL have port bist_run, output, 1, the BIST generator run enable.
REQ-013 The block SHALL have port mux_sel, output, 1, the mux select.
REQ-014 The block SHALL have port fifo_push, output, 1, the FIFO write strobe (fifo_inp_rts).
REQ-015 The block SHALL have port ro_fifo_overrun, output, 1, the sticky overrun flag.
REQ-016 The block SHALL have port ro_drain_tmo, output, 1, the sticky drain-timeout flag.
REQ-017 The block SHALL have port ro_i2si_state, output, 2, the current FSM state.
REQ-018 The block SHALL have port ro_i2si_sample_cnt, output, 16, the count of pushed samples.

Function
REQ-019 The FSM SHALL use the encoding IDLE=0, ARM=1, RUN=2, DRAIN=3, and ro_i2si_state SHALL equal the state register.
REQ-020 In IDLE with rf_i2si_en=1, the FSM SHALL latch mode=rf_bist_en and go to RUN if mode=1, otherwise to ARM.
REQ-021 In ARM, the FSM SHALL go to RUN on a ws falling edge (ws_q=1, i2si_ws=0) and to IDLE if rf_i2si_en=0; rf_i2si_en=0 SHALL take priority when both occur.
REQ-022 In RUN, deser_en SHALL be ~mode and bist_run SHALL be mode; in all other states both SHALL be 0.
REQ-023 mux_sel SHALL equal the latched mode in every state.
REQ-024 fifo_push SHALL be asserted in the same cycle as src_xfc, and only when in RUN with src_xfc=1 and fifo_inp_rtr=1 (zero latency).
REQ-025 In RUN, src_xfc=1 with fifo_inp_rtr=0 SHALL drop the sample and set ro_fifo_overrun on the next edge.
REQ-026 RUN SHALL go to DRAIN when rf_i2si_en=0 or rf_bist_en differs from mode; a src_xfc in that same cycle SHALL still be pushed.
REQ-027 DRAIN SHALL clear the timeout counter on entry.
REQ-028 DRAIN SHALL go to IDLE when fifo_out_rts=0.
REQ-029 If fifo_out_rts stays 1 until the timeout counter reaches all-ones, DRAIN SHALL go to IDLE and set ro_drain_tmo.
REQ-030 If fifo_out_rts=0 and the timeout is reached in the same cycle, the FSM SHALL go to IDLE without setting ro_drain_tmo.
REQ-031 trig_i2si_fifo_overrun_clr SHALL clear ro_fifo_overrun and ro_drain_tmo; a set event SHALL win over a clear in the same cycle.
REQ-032 A mode change requested in IDLE SHALL be latched only at the next IDLE exit.

Reset
REQ-033 While rst=0, the block SHALL hold state=IDLE, mode=0, ws_q=1, the timeout counter at 0, and every output at 0.
REQ-034 A reset asserted mid-RUN or mid-DRAIN SHALL abort immediately, with no drain and no push.

Configuration
REQ-035 With I2SI_SAMPLE_CNT_EN defined, ro_i2si_sample_cnt SHALL increment on each fifo_push, wrap 0xFFFF->0x0000, and clear on every IDLE exit.
REQ-036 Without I2SI_SAMPLE_CNT_EN, ro_i2si_sample_cnt SHALL be constant 0 and no counter flops SHALL be synthesized.

Verification
REQ-037 rf_i2si_en=1, rf_bist_en=0, ws 1->0 after 10 cycles -> ARM for 10 cycles, then RUN with deser_en=1 and mux_sel=0.
REQ-038 RUN, BIST mode, 5 src_xfc pulses with fifo_inp_rtr=1 -> 5 fifo_push pulses with zero latency, and sample_cnt=5 (macro defined).
REQ-039 RUN, src_xfc=1 with fifo_inp_rtr=0 -> no push, and ro_fifo_overrun=1 next cycle; a simultaneous set and clear -> flag remains 1.
REQ-040 rf_bist_en toggled in RUN with fifo_out_rts=1 for 4 cycles -> DRAIN for 4 cycles with both enables 0, then IDLE, then restart in the new mode.
REQ-041 DRAIN with fifo_out_rts stuck at 1 and DRAIN_TMO_W=8 -> IDLE after 255 cycles and ro_drain_tmo=1; a clear pulse -> 0.
REQ-042 rst pulsed low during RUN -> state 0 and all outputs 0 asynchronously; sample_cnt wraps 0xFFFF->0 on the 65536th push.
